// File: rtl/fir_xifu_pkg.sv
// ============================================================================
// fir_xifu_pkg : shared types and constants of the FIR X-interface unit
// Rev 1.0
// ============================================================================
`default_nettype none

package fir_xifu_pkg;

  localparam int XIF_ID_WIDTH   = 4;
  localparam int XIF_ADDR_WIDTH = 32;

  localparam logic [3:0] MEM_BE_WORD   = 4'hF;
  localparam logic [2:0] MEM_SIZE_WORD = 3'b010;
  localparam logic [1:0] PRIV_LVL_M    = 2'b11;

  typedef enum logic [2:0] {
    INSTR_NONE     = 3'd0,
    INSTR_XFIRLW   = 3'd1,
    INSTR_XFIRSW   = 3'd2,
    INSTR_XFIRDOTP = 3'd3
  } fir_xifu_instr_e;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_REQ  = 2'd1,
    EX_WAIT = 2'd2
  } fir_xifu_ex_state_e;

  typedef struct packed {
    logic                        valid;
    fir_xifu_instr_e             instr;
    logic [XIF_ID_WIDTH-1:0]     id;
    logic [4:0]                  rs1;
    logic [XIF_ADDR_WIDTH-1:0]   base;
    logic [XIF_ADDR_WIDTH-1:0]   wdata;
    logic signed [11:0]          imm;
  } fir_xifu_id2ex_t;

  typedef struct packed {
    fir_xifu_instr_e             instr;
    logic [XIF_ID_WIDTH-1:0]     id;
    logic [4:0]                  rs1;
    logic [XIF_ADDR_WIDTH-1:0]   next_addr;
  } fir_xifu_ex2wb_t;

  // X-interface memory channel payloads (only the fields this unit touches)
  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0]     id;
    logic [XIF_ADDR_WIDTH-1:0]   addr;
    logic [1:0]                  mode;
    logic                        we;
    logic [2:0]                  size;
    logic [3:0]                  be;
    logic [XIF_ADDR_WIDTH-1:0]   wdata;
  } x_mem_req_t;

  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0]     id;
  } x_mem_result_t;

  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0]     id;
    logic                        commit_kill;
  } x_commit_t;

  function automatic logic is_mem_instr(input fir_xifu_instr_e instr);
    return (instr == INSTR_XFIRLW) || (instr == INSTR_XFIRSW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_xifu_ex.sv
// ============================================================================
// fir_xifu_ex : execute stage issuing one word memory request per XFIRLW/SW
// Rev 1.0
// ============================================================================
`default_nettype none

module fir_xifu_ex
  import fir_xifu_pkg::*;
#(
  parameter int X_ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // X-interface memory request channel
  output logic            xif_mem_valid_o,
  output x_mem_req_t      xif_mem_req_o,
  input  logic            xif_mem_ready_i,
  // X-interface memory result channel
  input  logic            xif_mem_result_valid_i,
  input  x_mem_result_t   xif_mem_result_i,
  // X-interface commit channel
  input  logic            xif_commit_valid_i,
  input  x_commit_t       xif_commit_i,
  // pipeline
  input  fir_xifu_id2ex_t id2ex_i,
  output logic            ex_ready_o,
  output fir_xifu_ex2wb_t ex2wb_o
);

  fir_xifu_ex_state_e    r_state;
  fir_xifu_ex_state_e    w_state_nxt;
  fir_xifu_ex2wb_t       r_ex2wb;
  x_mem_req_t            r_mem_req;

  logic                  w_result_hit;
  logic                  w_kill;
  logic                  w_load;
  logic                  w_clear;
  logic [X_ID_WIDTH-1:0] w_pend_id;
  logic [ADDR_WIDTH-1:0] w_imm_sext;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign w_pend_id    = r_ex2wb.id;
  assign w_result_hit = xif_mem_result_valid_i && (xif_mem_result_i.id == w_pend_id);
  assign w_kill       = xif_commit_valid_i && xif_commit_i.commit_kill &&
                        (xif_commit_i.id == w_pend_id);

  assign w_imm_sext  = {{(ADDR_WIDTH-12){id2ex_i.imm[11]}}, id2ex_i.imm};
  assign w_next_addr = id2ex_i.base + w_imm_sext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= EX_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ex_ready_o  = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      EX_IDLE: ex_ready_o = 1'b1;
      EX_REQ: begin
        // a handshake in the same cycle as a kill takes priority
        if (xif_mem_ready_i) begin
          w_state_nxt = EX_WAIT;
        end else if (w_kill) begin
          w_state_nxt = EX_IDLE;
          w_clear     = 1'b1;
        end
      end
      EX_WAIT: begin
        if (w_result_hit) begin
          ex_ready_o  = 1'b1;
          w_state_nxt = EX_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = EX_IDLE;
    endcase
    // non-memory instructions are consumed without affecting this stage
    if (ex_ready_o && id2ex_i.valid && is_mem_instr(id2ex_i.instr)) begin
      w_load      = 1'b1;
      w_clear     = 1'b0;
      w_state_nxt = EX_REQ;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ex2wb   <= '0;
      r_mem_req <= '0;
    end else if (w_load) begin
      r_ex2wb.instr      <= id2ex_i.instr;
      r_ex2wb.id         <= id2ex_i.id;
      r_ex2wb.rs1        <= id2ex_i.rs1;
      r_ex2wb.next_addr  <= w_next_addr;
      r_mem_req.id       <= id2ex_i.id;
      r_mem_req.addr     <= id2ex_i.base;
      r_mem_req.mode     <= PRIV_LVL_M;
      r_mem_req.we       <= (id2ex_i.instr == INSTR_XFIRSW);
      r_mem_req.size     <= MEM_SIZE_WORD;
      r_mem_req.be       <= MEM_BE_WORD;
      r_mem_req.wdata    <= (id2ex_i.instr == INSTR_XFIRSW) ? id2ex_i.wdata : '0;
    end else if (w_clear) begin
      r_ex2wb.instr <= INSTR_NONE;
    end
  end

  assign xif_mem_valid_o = (r_state == EX_REQ);
  assign xif_mem_req_o   = r_mem_req;
  assign ex2wb_o         = r_ex2wb;

endmodule

`default_nettype wire

// File: tb/tb_fir_xifu_ex.sv
// ============================================================================
// tb_fir_xifu_ex : directed bench with a transaction-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fir_xifu_ex;
  import fir_xifu_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_valid;
  x_mem_req_t      mem_req;
  logic            mem_ready;
  logic            res_valid;
  x_mem_result_t   res;
  logic            c_valid;
  x_commit_t       cmt;
  fir_xifu_id2ex_t id2ex;
  logic            ex_ready;
  fir_xifu_ex2wb_t ex2wb;

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  fir_xifu_ex #(.X_ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .xif_mem_valid_o       (mem_valid),
    .xif_mem_req_o         (mem_req),
    .xif_mem_ready_i       (mem_ready),
    .xif_mem_result_valid_i(res_valid),
    .xif_mem_result_i      (res),
    .xif_commit_valid_i    (c_valid),
    .xif_commit_i          (cmt),
    .id2ex_i               (id2ex),
    .ex_ready_o            (ex_ready),
    .ex2wb_o               (ex2wb)
  );

  // Reference model: one transaction that is either still requesting
  // the bus or has been issued and is awaiting its result.
  typedef struct packed {
    logic            requesting;
    logic            awaiting;
    fir_xifu_ex2wb_t wb;
    x_mem_req_t      req;
  } model_t;

  model_t m = '0;

  function automatic logic model_ready(input model_t s);
    logic hit;
    hit = s.awaiting && res_valid && (res.id == s.wb.id);
    return !(s.requesting || s.awaiting) || hit;
  endfunction

  function automatic model_t model_step(input model_t s);
    model_t n;
    logic   st;
    n = s;
    if (s.requesting) begin
      if (mem_ready) begin
        n.requesting = 1'b0;
        n.awaiting   = 1'b1;
      end else if (c_valid && cmt.commit_kill && cmt.id == s.wb.id) begin
        n.requesting = 1'b0;
        n.wb.instr   = INSTR_NONE;
      end
    end else if (s.awaiting && res_valid && res.id == s.wb.id) begin
      n.awaiting = 1'b0;
      n.wb.instr = INSTR_NONE;
    end
    if (id2ex.valid && model_ready(s) &&
        (id2ex.instr == INSTR_XFIRLW || id2ex.instr == INSTR_XFIRSW)) begin
      st              = (id2ex.instr == INSTR_XFIRSW);
      n.requesting    = 1'b1;
      n.awaiting      = 1'b0;
      n.wb.instr      = id2ex.instr;
      n.wb.id         = id2ex.id;
      n.wb.rs1        = id2ex.rs1;
      n.wb.next_addr  = id2ex.base + 32'($signed(id2ex.imm));
      n.req.id        = id2ex.id;
      n.req.addr      = id2ex.base;
      n.req.mode      = 2'b11;
      n.req.we        = st;
      n.req.size      = 3'b010;
      n.req.be        = 4'hF;
      n.req.wdata     = st ? id2ex.wdata : 32'h0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_step(m);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_valid && mem_ready) hs_cnt = hs_cnt + 1;
    chk("ex_ready", 128'(ex_ready), 128'(model_ready(m)));
    chk("mem_valid", 128'(mem_valid), 128'(m.requesting));
    if (m.requesting) chk("mem_req", 128'(mem_req), 128'(m.req));
    chk("ex2wb", 128'(ex2wb), 128'(m.wb));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input fir_xifu_instr_e instr, input logic [3:0] id,
                       input logic [4:0] rs1, input logic [31:0] base,
                       input logic [31:0] wdata, input logic [11:0] imm);
    id2ex.valid = 1'b1;
    id2ex.instr = instr;
    id2ex.id    = id;
    id2ex.rs1   = rs1;
    id2ex.base  = base;
    id2ex.wdata = wdata;
    id2ex.imm   = imm;
  endtask

  task automatic result(input logic v, input logic [3:0] id);
    res_valid = v;
    res.id    = id;
  endtask

  int hs0;

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    res_valid = 1'b0;
    res = '0;
    c_valid = 1'b0;
    cmt = '0;
    id2ex = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 128'(ex_ready), 128'(1));
    chk("rst_mem_valid", 128'(mem_valid), 128'(0));
    chk("rst_ex2wb", 128'(ex2wb), 128'(0));

    // plain load with immediate handshake
    issue(INSTR_XFIRLW, 4'd3, 5'd5, 32'h0000_1000, 32'h0, 12'd4);
    tick();
    id2ex = '0;
    chk("lw_valid", 128'(mem_valid), 128'(1));
    chk("lw_addr", 128'(mem_req.addr), 128'(32'h1000));
    chk("lw_we", 128'(mem_req.we), 128'(0));
    chk("lw_be", 128'(mem_req.be), 128'(4'hF));
    chk("lw_size", 128'(mem_req.size), 128'(3'b010));
    chk("lw_next", 128'(ex2wb.next_addr), 128'(32'h1004));
    chk("lw_rs1", 128'(ex2wb.rs1), 128'(5));
    chk("model_lw_next", 128'(m.wb.next_addr), 128'(32'h1004));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("lw_wait_valid", 128'(mem_valid), 128'(0));
    chk("lw_wait_instr", 128'(ex2wb.instr), 128'(INSTR_XFIRLW));
    result(1'b1, 4'd3);
    #1 chk("lw_hit_ready", 128'(ex_ready), 128'(1));
    tick();
    result(1'b0, 4'd0);
    chk("lw_done_instr", 128'(ex2wb.instr), 128'(INSTR_NONE));

    // store with back-pressure
    hs0 = hs_cnt;
    issue(INSTR_XFIRSW, 4'd5, 5'd7, 32'h0000_2000, 32'hDEAD_BEEF, 12'hFF8);
    tick();
    id2ex = '0;
    for (int i = 0; i < 3; i++) begin
      chk("sw_hold_valid", 128'(mem_valid), 128'(1));
      chk("sw_hold_addr", 128'(mem_req.addr), 128'(32'h2000));
      chk("sw_hold_wdata", 128'(mem_req.wdata), 128'(32'hDEAD_BEEF));
      chk("sw_hold_we", 128'(mem_req.we), 128'(1));
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("sw_one_handshake", 128'(hs_cnt - hs0), 128'(1));
    chk("sw_next", 128'(ex2wb.next_addr), 128'(32'h1FF8));
    chk("model_sw_next", 128'(m.wb.next_addr), 128'(32'h1FF8));
    result(1'b1, 4'd5);
    tick();
    result(1'b0, 4'd0);

    // back-to-back: new accept on the result cycle
    issue(INSTR_XFIRLW, 4'd1, 5'd2, 32'h0000_3000, 32'h0, 12'h010);
    tick();
    id2ex = '0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    issue(INSTR_XFIRLW, 4'd2, 5'd3, 32'h0000_4000, 32'h0, 12'hFFC);
    result(1'b1, 4'd1);
    #1 chk("b2b_ready", 128'(ex_ready), 128'(1));
    tick();
    id2ex = '0;
    result(1'b0, 4'd0);
    chk("b2b_valid", 128'(mem_valid), 128'(1));
    chk("b2b_addr", 128'(mem_req.addr), 128'(32'h4000));
    chk("b2b_id", 128'(ex2wb.id), 128'(2));
    chk("b2b_next", 128'(ex2wb.next_addr), 128'(32'h3FFC));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    result(1'b1, 4'd2);
    tick();
    result(1'b0, 4'd0);

    // kill before handshake
    issue(INSTR_XFIRLW, 4'd6, 5'd1, 32'h0000_5000, 32'h0, 12'd0);
    tick();
    id2ex = '0;
    c_valid = 1'b1;
    cmt.commit_kill = 1'b1;
    cmt.id = 4'd6;
    tick();
    c_valid = 1'b0;
    cmt = '0;
    chk("kill_valid", 128'(mem_valid), 128'(0));
    chk("kill_instr", 128'(ex2wb.instr), 128'(INSTR_NONE));

    // kill coinciding with the handshake, then kill during WAIT
    issue(INSTR_XFIRSW, 4'd7, 5'd2, 32'h0000_6000, 32'h1234_5678, 12'd4);
    tick();
    id2ex = '0;
    c_valid = 1'b1;
    cmt.commit_kill = 1'b1;
    cmt.id = 4'd7;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("killhs_valid", 128'(mem_valid), 128'(0));
    chk("killhs_instr", 128'(ex2wb.instr), 128'(INSTR_XFIRSW));
    chk("killhs_ready", 128'(ex_ready), 128'(0));
    tick();
    chk("killwait_instr", 128'(ex2wb.instr), 128'(INSTR_XFIRSW));
    c_valid = 1'b0;
    cmt = '0;
    result(1'b1, 4'd7);
    tick();
    result(1'b0, 4'd0);

    // address wrap and stray result
    issue(INSTR_XFIRLW, 4'd9, 5'd4, 32'hFFFF_FFFC, 32'h0, 12'd8);
    tick();
    id2ex = '0;
    chk("wrap_next", 128'(ex2wb.next_addr), 128'(32'h0000_0004));
    chk("model_wrap_next", 128'(m.wb.next_addr), 128'(32'h0000_0004));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    result(1'b1, 4'd10);
    #1 chk("stray_ready", 128'(ex_ready), 128'(0));
    tick();
    result(1'b0, 4'd0);
    chk("stray_instr", 128'(ex2wb.instr), 128'(INSTR_XFIRLW));
    chk("stray_wait_ready", 128'(ex_ready), 128'(0));

    // asynchronous reset mid-WAIT, then a late result
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(mem_valid), 128'(0));
    chk("arst_ex2wb", 128'(ex2wb), 128'(0));
    chk("arst_ready", 128'(ex_ready), 128'(1));
    @(negedge clk);
    #2 rst = 1'b0;
    tick();
    result(1'b1, 4'd9);
    #1 chk("late_ready", 128'(ex_ready), 128'(1));
    tick();
    result(1'b0, 4'd0);
    chk("late_ex2wb", 128'(ex2wb), 128'(0));
    chk("late_valid", 128'(mem_valid), 128'(0));

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_xifu_ex.md
Name: fir_xifu_ex

Overview:
- Execute stage of the FIR eXtension-interface unit, directly upstream of the writeback stage.
- Takes decoded XFIRLW/XFIRSW instructions from the ID stage and issues exactly one word memory request per instruction on the X-interface memory channel.
- Computes the post-incremented base address.
- Holds the ex2wb register stable until the matching memory result returns.

Parameters:
- X_ID_WIDTH, 4: width of X-interface instruction id.
- ADDR_WIDTH, 32: address and data width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- xif_mem_o  modport  -  cv32e40x_if_xif.coproc_mem. Drives mem_valid, mem_req.{addr,we,be,wdata,id,mode,size}. Samples mem_ready.
- xif_mem_result_i  modport  -  cv32e40x_if_xif.coproc_mem_result. Samples mem_result_valid and mem_result.id.
- xif_commit_i  modport  -  cv32e40x_if_xif.coproc_commit. Samples commit_valid, commit.id, commit.commit_kill.
- id2ex_i  in  fir_xifu_id2ex_t  fields: valid, instr, id, rs1 (5b), base (32b), wdata (32b), imm (12b signed).
- ex_ready_o  out  1  EX can accept id2ex_i this cycle.
- ex2wb_o  out  fir_xifu_ex2wb_t  fields: instr, id, rs1, next_addr.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - FSM goes to IDLE.
  - ex2wb_o is all zero; instr=INSTR_NONE.
  - mem_valid=0 and mem_req=0.
  - ex_ready_o=1.
- FSM states: IDLE, REQ, WAIT.
- Accept condition: id2ex_i.valid & ex_ready_o & instr in {XFIRLW, XFIRSW}.
  - ex_ready_o = (state==IDLE) | (state==WAIT & result_hit).
  - result_hit = mem_result_valid & mem_result.id == ex2wb_o.id.
  - Any other instr with valid is consumed (ready honoured) with no state change.
- On accept, the ex2wb register loads on the next edge:
  - next_addr = base + sext(imm), mod 2^32; overflow wraps silently.
  - instr, id and rs1 are copied from id2ex_i.
  - Request registers load: addr=base (post-increment semantics), we=(instr==XFIRSW), be=4'hF, size=3'b010, mode=M-mode, wdata=wdata for stores and 0 for loads, id=id.
  - FSM goes to REQ.
- REQ:
  - mem_valid=1; request fields are held stable until the handshake.
  - mem_valid & mem_ready → WAIT.
  - Kill before the handshake (commit_valid & commit_kill & commit.id==ex2wb_o.id, with mem_ready=0 in the same cycle) → IDLE. mem_valid drops the next cycle and ex2wb_o.instr is cleared to INSTR_NONE.
  - If kill and mem_ready arrive in the same cycle, the handshake wins → WAIT.
- WAIT:
  - mem_valid=0; ex2wb_o is held so WB can consume it when the result arrives.
  - result_hit without a new accept → IDLE; ex2wb_o.instr is cleared the next cycle.
  - result_hit with a new accept → REQ; ex2wb reloads (back-to-back, zero bubble).
  - Kills in WAIT are ignored, since the memory op is already committed.
- mem_result_valid with a non-matching id is ignored in every state.
- Latency: accept at cycle N → mem_valid at N+1 → earliest WAIT at N+2. At most one outstanding request.
- Reset mid-REQ or mid-WAIT aborts immediately; a result arriving later is ignored.

Decomposition:
- Shared fir_xifu_pkg holds:
  - fir_xifu_id2ex_t and fir_xifu_ex2wb_t;
  - instr encoding enum (INSTR_NONE, INSTR_XFIRLW, INSTR_XFIRSW, …);
  - ex state enum;
  - constants MEM_BE_WORD=4'hF and MEM_SIZE_WORD=3'b010.
- No sub-module; the FSM, address adder and request registers stay in one module.

Test Plan:
1. XFIRLW base=0x1000, imm=4, id=3, mem_ready=1 on first REQ cycle → mem_req.addr=0x1000, we=0, be=F. ex2wb_o.next_addr=0x1004, rs1 held. Result id=3 two cycles later → IDLE.
2. XFIRSW base=0x2000, imm=-8, wdata=0xDEADBEEF, mem_ready low for 3 cycles → addr, wdata and we=1 stable all 3 cycles. next_addr=0x1FF8. One handshake only.
3. Back-to-back: second XFIRLW presented while WAIT; result id matches → ex_ready_o=1 that cycle, second request mem_valid the next cycle, no bubble.
4. Kill in REQ with mem_ready=0, id match → IDLE, mem_valid=0 next cycle, ex2wb_o.instr=NONE. Repeat with kill coinciding with mem_ready=1 → proceeds to WAIT.
5. Wrap and stray results: base=0xFFFFFFFC, imm=8 → next_addr=0x00000004. A result with id≠pending in WAIT → remains WAIT.
6. Assert rst_i asynchronously mid-WAIT → mem_valid=0 and ex2wb_o zero without a clock edge. A late result after release is ignored and ex_ready_o=1.
